// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, NB_DATA data bits (LSB first), 1 stop bit, no parity.
// Works from a 16x oversampling tick strobe and samples each bit at its centre.
module uart_rx #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_STOP = 16
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rxdone,
    output logic               o_frame_err
);

    localparam int unsigned NB_S = ($clog2(NB_STOP) > 4) ? $clog2(NB_STOP) : 4;
    localparam int unsigned NB_N = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [NB_S-1:0] S_MID  = NB_S'(7);
    localparam logic [NB_S-1:0] S_BIT  = NB_S'(15);
    localparam logic [NB_S-1:0] S_STOP = NB_S'(NB_STOP - 1);
    localparam logic [NB_N-1:0] N_LAST = NB_N'(NB_DATA - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic   [NB_S-1:0]    s_q, s_d;
    logic   [NB_N-1:0]    n_q, n_d;
    logic   [NB_DATA-1:0] sh_q, sh_d;
    logic   [NB_DATA-1:0] data_q, data_d;
    logic                 rxdone_q, rxdone_d;
    logic                 err_q, err_d;

    // Two-flop synchronizer; both stages reset to the idle line level.
    logic rx_meta_q;
    logic rx_s;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s      <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            s_q      <= '0;
            n_q      <= '0;
            sh_q     <= '0;
            data_q   <= '0;
            rxdone_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            n_q      <= n_d;
            sh_q     <= sh_d;
            data_q   <= data_d;
            rxdone_q <= rxdone_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        sh_d     = sh_q;
        data_d   = data_q;
        rxdone_d = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    s_d     = '0;
                end
            end

            StStart: begin
                if (i_tick) begin
                    if (s_q == S_MID) begin
                        // A line that is high again mid start bit was only a glitch.
                        if (!rx_s) begin
                            state_d = StData;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        s_d = s_q + NB_S'(1);
                    end
                end
            end

            StData: begin
                if (i_tick) begin
                    if (s_q == S_BIT) begin
                        sh_d = {rx_s, sh_q[NB_DATA-1:1]};
                        s_d  = '0;
                        if (n_q == N_LAST) begin
                            state_d = StStop;
                        end else begin
                            n_d = n_q + NB_N'(1);
                        end
                    end else begin
                        s_d = s_q + NB_S'(1);
                    end
                end
            end

            StStop: begin
                if (i_tick) begin
                    if (s_q == S_STOP) begin
                        // Data is delivered even when the stop bit is low.
                        data_d   = sh_q;
                        err_d    = ~rx_s;
                        rxdone_d = 1'b1;
                        s_d      = '0;
                        state_d  = StIdle;
                    end else begin
                        s_d = s_q + NB_S'(1);
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign o_data      = data_q;
    assign o_rxdone    = rxdone_q;
    assign o_frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial-line model drives frames and pushes the expected
// {frame_err, data} into a scoreboard that a monitor pops on every o_rxdone pulse.
module tb_uart_rx;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_data;
    logic       o_rxdone;
    logic       o_frame_err;

    int n_checks = 0;
    int n_pass   = 0;

    int div_cnt        = 0;
    int tick_cnt       = 0;
    int start_tick     = 0;
    int last_done_tick = 0;
    int done_count     = 0;

    logic [8:0] exp_q[$];
    logic [8:0] exp_e;
    logic [7:0] prev_data = 8'h00;
    logic       prev_err  = 1'b0;
    logic       prev_done = 1'b0;

    uart_rx #(
        .NB_DATA(8),
        .NB_STOP(16)
    ) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_tick     (tick),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_rxdone   (o_rxdone),
        .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    // Free-running tick strobe, one clk wide every TICK_DIV clocks.
    always @(posedge clk) begin
        if (tick) tick_cnt <= tick_cnt + 1;
        if (div_cnt == TICK_DIV - 1) begin
            div_cnt <= 0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1;
            tick    <= 1'b0;
        end
    end

    // Scoreboard monitor: pops on each completion, checks pulse width and output stability.
    always @(negedge clk) begin
        if (!i_rst_n) begin
            prev_data = 8'h00;
            prev_err  = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (o_rxdone) begin
                done_count++;
                last_done_tick = tick_cnt;
                n_checks++;
                if (prev_done) $display("FAIL rxdone_width: high on consecutive cycles, required 1 cycle");
                else n_pass++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_rxdone: data=%02h err=%0b, required no pulse",
                             o_data, o_frame_err);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({o_frame_err, o_data} !== exp_e)
                        $display("FAIL scoreboard: got err=%0b data=%02h, required err=%0b data=%02h",
                                 o_frame_err, o_data, exp_e[8], exp_e[7:0]);
                    else n_pass++;
                end
            end else begin
                n_checks++;
                if (o_data !== prev_data || o_frame_err !== prev_err)
                    $display("FAIL output_stable: data=%02h err=%0b changed without rxdone (was %02h %0b)",
                             o_data, o_frame_err, prev_data, prev_err);
                else n_pass++;
            end
            prev_data = o_data;
            prev_err  = o_frame_err;
            prev_done = o_rxdone;
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            while (!tick) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int stop_ticks, input logic stop_val);
        exp_q.push_back({~stop_val, d});
        start_tick = tick_cnt + 1;
        i_rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            wait_ticks(16);
        end
        i_rx = stop_val;
        wait_ticks(stop_ticks);
        i_rx = 1'b1;
    endtask

    task automatic wait_drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_data, o_rxdone, o_frame_err} !== 10'd0)
            $display("FAIL reset_outputs: got data=%02h done=%0b err=%0b, required all 0",
                     o_data, o_rxdone, o_frame_err);
        else n_pass++;
        i_rst_n = 1'b1;
        wait_ticks(40);
        n_checks++;
        if ({o_data, o_frame_err} !== 9'd0 || done_count !== 0)
            $display("FAIL idle_after_reset: data=%02h err=%0b pulses=%0d, required 0/0/0",
                     o_data, o_frame_err, done_count);
        else n_pass++;
    endtask

    task automatic test_single();
        int d0 = done_count;
        int lat;
        send_frame(8'hA5, 16, 1'b1);
        wait_ticks(8);
        wait_drain();
        lat = last_done_tick - start_tick;
        n_checks++;
        if (done_count - d0 !== 1)
            $display("FAIL single_count: got %0d pulses, required 1", done_count - d0);
        else n_pass++;
        n_checks++;
        if (o_data !== 8'hA5 || o_frame_err !== 1'b0)
            $display("FAIL single_data: got data=%02h err=%0b, required a5 0", o_data, o_frame_err);
        else n_pass++;
        n_checks++;
        if (lat < 151 || lat > 153)
            $display("FAIL single_latency: got %0d ticks, required 152 +/- 1", lat);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d0 = done_count;
        send_frame(8'h00, 16, 1'b1);
        send_frame(8'hFF, 16, 1'b1);
        send_frame(8'h3C, 16, 1'b1);
        wait_ticks(8);
        wait_drain();
        n_checks++;
        if (done_count - d0 !== 3 || exp_q.size() !== 0)
            $display("FAIL b2b_count: got %0d pulses (%0d pending), required 3 (0)",
                     done_count - d0, exp_q.size());
        else n_pass++;
        n_checks++;
        if (o_data !== 8'h3C || o_frame_err !== 1'b0)
            $display("FAIL b2b_last: got data=%02h err=%0b, required 3c 0", o_data, o_frame_err);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int d0 = done_count;
        i_rx = 1'b0;
        wait_ticks(4);
        i_rx = 1'b1;
        wait_ticks(32);
        n_checks++;
        if (done_count !== d0)
            $display("FAIL glitch_ignored: got %0d pulses, required 0", done_count - d0);
        else n_pass++;
        send_frame(8'h5A, 16, 1'b1);
        wait_ticks(8);
        wait_drain();
        n_checks++;
        if (done_count - d0 !== 1 || o_data !== 8'h5A)
            $display("FAIL glitch_frame: got %0d pulses data=%02h, required 1 5a",
                     done_count - d0, o_data);
        else n_pass++;
    endtask

    task automatic test_frame_err();
        // Stop bit held low past its sample, then released before the restart would qualify.
        send_frame(8'hC3, 12, 1'b0);
        wait_ticks(32);
        wait_drain();
        n_checks++;
        if (o_data !== 8'hC3 || o_frame_err !== 1'b1)
            $display("FAIL frame_err: got data=%02h err=%0b, required c3 1", o_data, o_frame_err);
        else n_pass++;
        send_frame(8'h11, 16, 1'b1);
        wait_ticks(8);
        wait_drain();
        n_checks++;
        if (o_data !== 8'h11 || o_frame_err !== 1'b0)
            $display("FAIL frame_err_clear: got data=%02h err=%0b, required 11 0",
                     o_data, o_frame_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int         d0 = done_count;
        logic [7:0] partial = 8'h96;
        i_rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            i_rx = partial[i];
            wait_ticks(16);
        end
        i_rst_n = 1'b0;
        i_rx    = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if ({o_data, o_rxdone, o_frame_err} !== 10'd0)
                $display("FAIL reset_mid_during: got data=%02h done=%0b err=%0b, required 0",
                         o_data, o_rxdone, o_frame_err);
            else n_pass++;
        end
        i_rst_n = 1'b1;
        wait_ticks(200);
        n_checks++;
        if (done_count !== d0 || o_data !== 8'h00 || o_frame_err !== 1'b0)
            $display("FAIL reset_mid_after: pulses=%0d data=%02h err=%0b, required 0 00 0",
                     done_count - d0, o_data, o_frame_err);
        else n_pass++;
        send_frame(8'h69, 16, 1'b1);
        wait_ticks(8);
        wait_drain();
        n_checks++;
        if (done_count - d0 !== 1 || o_data !== 8'h69 || o_frame_err !== 1'b0)
            $display("FAIL reset_mid_next: pulses=%0d data=%02h err=%0b, required 1 69 0",
                     done_count - d0, o_data, o_frame_err);
        else n_pass++;
    endtask

    task automatic test_break();
        int d0 = done_count;
        // Released just after the third break frame so no frame straddles the release.
        repeat (3) exp_q.push_back({1'b1, 8'h00});
        i_rx = 1'b0;
        wait_ticks(460);
        i_rx = 1'b1;
        wait_ticks(32);
        wait_drain();
        n_checks++;
        if (done_count - d0 !== 3 || exp_q.size() !== 0)
            $display("FAIL break_count: got %0d pulses (%0d pending), required 3 (0)",
                     done_count - d0, exp_q.size());
        else n_pass++;
        n_checks++;
        if (o_data !== 8'h00 || o_frame_err !== 1'b1)
            $display("FAIL break_data: got data=%02h err=%0b, required 00 1", o_data, o_frame_err);
        else n_pass++;
        send_frame(8'hE7, 16, 1'b1);
        wait_ticks(8);
        wait_drain();
        n_checks++;
        if (o_data !== 8'hE7 || o_frame_err !== 1'b0)
            $display("FAIL break_recover: got data=%02h err=%0b, required e7 0",
                     o_data, o_frame_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_break();
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_empty: %0d frames never received, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that recovers NB_DATA-bit frames (1 start, NB_DATA data LSB first, 1 stop, no parity) from a serial line using the 16x oversampling tick produced by `baudrate_generator`. It is the receive-side counterpart of `uart_tx`. It shares the same `i_tick` strobe and the same tick-count conventions, so `uart_tx` looped back into `uart_rx` forms a self-checking link.

## Interface
- NB_DATA, 8, data bits per frame
- NB_STOP, 16, ticks spent in the stop bit before sampling and completing (16 = one stop bit)
- clk  input  1  system clock, all logic on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_tick  input  1  one-clk-wide oversampling strobe, 16 per bit period
- i_rx  input  1  serial line, asynchronous to clk, idle high
- o_data  output  NB_DATA  last received byte, held until next completion
- o_rxdone  output  1  one-clk pulse: o_data/o_frame_err updated
- o_frame_err  output  1  stop bit sampled low on the last completed frame

## Operation
- i_rx passes through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value `rx_s`.
- Tick counter `s`: width max(4, $clog2(NB_STOP)), increments only on cycles with i_tick=1. Bit counter `n`: width $clog2(NB_DATA). Shift register `sh`: NB_DATA bits.
- State machine states:
  - IDLE: if rx_s==0, go to START with s=0. No tick is required.
  - START: on each tick, if s==7 then check rx_s. If rx_s==0, go to DATA with s=0 and n=0. If rx_s==1, treat the low as a glitch and return to IDLE. Otherwise s++.
  - DATA: on each tick, if s==15 then shift `sh <= {rx_s, sh[NB_DATA-1:1]}` (LSB first) and set s=0. Then, if n==NB_DATA-1, go to STOP; else n++. Otherwise s++.
  - STOP: on each tick, if s==NB_STOP-1 then set o_data<=sh, o_frame_err<=~rx_s, o_rxdone<=1, and go to IDLE. Otherwise s++.
- Sampling lands mid-bit: 8 ticks into the start bit, then every 16 ticks.
- A framing error still delivers data: o_rxdone=1 and o_data is updated.
- After any completion, IDLE restarts immediately if rx_s is still low. A line held low (break) therefore produces repeated frames of 0x00 with o_frame_err=1. This is the required behaviour.
- Reset (any time, including mid-frame): state=IDLE, s=0, n=0, sh=0, o_data=0, o_rxdone=0, o_frame_err=0, synchronizer=1. A partial frame is discarded, never reported.

## Timing
- Input latency: 2 clk from an i_rx edge to rx_s.
- Start detection: IDLE→START in the clk cycle after rx_s goes low.
- o_rxdone rises on the clk edge of the qualifying tick in STOP. It is high for exactly one clk cycle, regardless of tick spacing.
- o_data and o_frame_err change only on the cycle o_rxdone is set, and are stable otherwise.
- Frame length from rx_s falling to o_rxdone: 8 + 16·NB_DATA + NB_STOP ticks (152 ticks at defaults), plus 1 clk.
- Back-to-back frames: a new start bit arriving immediately after the stop-bit sample must be accepted with no lost frame. The detector returns to IDLE 8 ticks before the nominal end of the stop bit.
- Ticks arriving in IDLE are ignored, and s does not advance.

## Test plan
Common bench setup: clk period 10 ns; `baudrate_generator` with NC_PER_TICK=163 gives 1 bit = 16 ticks = 2608 clk.
1. Single frame: drive 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) → exactly one o_rxdone pulse of 1 clk, o_data=0xA5, o_frame_err=0. o_rxdone rises 152 ticks ±1 tick after the start edge.
2. Loopback with `uart_tx` (o_data→i_rx), sending 0x00, 0xFF, 0x3C back-to-back → three o_rxdone pulses with o_data=0x00, 0xFF, 0x3C in order, o_frame_err=0 each time.
3. Start glitch: pull i_rx low for 4 ticks, then high, then send 0x5A after 32 ticks → no o_rxdone for the glitch; one o_rxdone with o_data=0x5A.
4. Framing error: send 0xC3 with the stop bit driven low, then release high → o_rxdone=1, o_data=0xC3, o_frame_err=1. A following good frame 0x11 clears o_frame_err to 0.
5. Reset mid-frame: assert i_rst_n=0 for 5 clk after 3 data bits of 0x96 → all outputs 0 during and after reset, no o_rxdone for the partial frame. A subsequent 0x69 is received correctly.
6. Break: hold i_rx low for 30 bit periods → repeated o_rxdone pulses with o_data=0x00 and o_frame_err=1. After release and a valid 0xE7 frame, o_data=0xE7 and o_frame_err=0.
